// File: rtl/fetch_queue.sv
// fetch_queue: IF stage that owns the PC and buffers fetched instructions in a
// DEPTH-entry circular queue of {inst, PC, PC+4}, decoupling fetch from ID stalls.
// A redirect flushes the queue and reloads the PC.
// Optional feature: define FETCHQ_BYPASS_EN to forward imem data straight to ID
// when the queue is empty (adds an imem->ID combinational path).
module fetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h1_0000,
   parameter logic [31:0]     NOP_INST = 32'h13
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [XLEN-1:0]            o_PC,
   input  logic [31:0]                i_inst,
   input  logic                       i_redirect,
   input  logic [XLEN-1:0]            i_redirectPC,
   input  logic                       i_deqReady,
   output logic                       o_valid,
   output logic [31:0]                o_inst,
   output logic [XLEN-1:0]            o_instPC,
   output logic [XLEN-1:0]            o_instPCPlus4,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]     mem_inst [DEPTH];
   logic [XLEN-1:0] mem_pc   [DEPTH];
   logic [XLEN-1:0] mem_pc4  [DEPTH];

   logic [XLEN-1:0] pc_q;
   logic [AW-1:0]   head_q, tail_q;
   logic [CW-1:0]   count_q;

   logic [XLEN-1:0] pc_plus4;
   logic            empty, full;
   logic            bypass_act;
   logic            deq, enq;
   logic            wr, pop;

   assign pc_plus4 = pc_q + XLEN'(4);
   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
   assign bypass_act = empty & ~i_redirect;
`else
   assign bypass_act = 1'b0;
`endif

   assign deq = o_valid & i_deqReady & ~i_redirect;
   assign enq = ~i_redirect & (~full | deq);
   // A bypassed instruction taken by ID the same cycle never touches storage.
   assign wr  = enq & ~(bypass_act & i_deqReady);
   assign pop = deq & ~empty;

   // Head presentation: stored entry, bypassed imem data, or NOP when nothing valid.
   always_comb begin
      o_valid       = ~empty | bypass_act;
      o_inst        = NOP_INST;
      o_instPC      = '0;
      o_instPCPlus4 = '0;
      if (bypass_act) begin
         o_inst        = i_inst;
         o_instPC      = pc_q;
         o_instPCPlus4 = pc_plus4;
      end else if (!empty) begin
         o_inst        = mem_inst[head_q];
         o_instPC      = mem_pc[head_q];
         o_instPCPlus4 = mem_pc4[head_q];
      end
   end

   assign o_PC    = pc_q;
   assign o_count = count_q;

   // Queue storage: payload needs no reset, validity comes from count.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_inst[tail_q] <= i_inst;
         mem_pc[tail_q]   <= pc_q;
         mem_pc4[tail_q]  <= pc_plus4;
      end
   end

   // PC, pointers and occupancy; redirect overrides everything and empties the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (i_redirect) begin
         pc_q    <= i_redirectPC;
         head_q  <= tail_q;
         count_q <= '0;
      end else begin
         if (enq) pc_q <= pc_plus4;
         if (wr)  tail_q <= tail_q + AW'(1);
         if (pop) head_q <= head_q + AW'(1);
         if (wr && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !wr) count_q <= count_q - CW'(1);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table for the reset/fill/full/redirect/wrap
// scenarios, then randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] o_PC;
   logic [31:0] i_inst;
   logic        i_redirect;
   logic [31:0] i_redirectPC;
   logic        i_deqReady;
   logic        o_valid;
   logic [31:0] o_inst;
   logic [31:0] o_instPC;
   logic [31:0] o_instPCPlus4;
   logic [2:0]  o_count;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk           (clk),
      .reset         (reset),
      .o_PC          (o_PC),
      .i_inst        (i_inst),
      .i_redirect    (i_redirect),
      .i_redirectPC  (i_redirectPC),
      .i_deqReady    (i_deqReady),
      .o_valid       (o_valid),
      .o_inst        (o_inst),
      .o_instPC      (o_instPC),
      .o_instPCPlus4 (o_instPCPlus4),
      .o_count       (o_count)
   );

   // Instruction memory: PC-tagged words, one fixed instruction at 0x3000.
   function automatic logic [31:0] imem(input logic [31:0] pc);
      if (pc == 32'h3000) return 32'h0050_0093;
      return {pc[29:0], 2'b11};
   endfunction

   assign i_inst = imem(o_PC);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset();
      chk("rst_pc", o_PC, 32'h1_0000);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_inst", o_inst, 32'h13);
      chk("rst_count", 32'(o_count), 32'd0);
      chk("rst_ipc", o_instPC, 32'd0);
      chk("rst_ipc4", o_instPCPlus4, 32'd0);
   endtask

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] e_cnt;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_ipc;
      logic [31:0] e_ipc4;
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mpc;

   initial begin
      vec_t tbl[20];
      tbl[0]  = '{1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h1_0000,  32'h0,         32'h0};
      tbl[1]  = '{1'b0, 32'h0,         1'b0, 1, 1'b1, 32'h1_0004,  32'h1_0000,    32'h1_0004};
      tbl[2]  = '{1'b0, 32'h0,         1'b0, 2, 1'b1, 32'h1_0008,  32'h1_0000,    32'h1_0004};
      tbl[3]  = '{1'b0, 32'h0,         1'b0, 3, 1'b1, 32'h1_000c,  32'h1_0000,    32'h1_0004};
      tbl[4]  = '{1'b0, 32'h0,         1'b0, 4, 1'b1, 32'h1_0010,  32'h1_0000,    32'h1_0004};
      tbl[5]  = '{1'b0, 32'h0,         1'b0, 4, 1'b1, 32'h1_0010,  32'h1_0000,    32'h1_0004};
      tbl[6]  = '{1'b0, 32'h0,         1'b1, 4, 1'b1, 32'h1_0010,  32'h1_0000,    32'h1_0004};
      tbl[7]  = '{1'b1, 32'h2000,      1'b1, 4, 1'b1, 32'h1_0014,  32'h1_0004,    32'h1_0008};
      tbl[8]  = '{1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h2000,    32'h0,         32'h0};
      tbl[9]  = '{1'b0, 32'h0,         1'b0, 1, 1'b1, 32'h2004,    32'h2000,      32'h2004};
      tbl[10] = '{1'b0, 32'h0,         1'b0, 2, 1'b1, 32'h2008,    32'h2000,      32'h2004};
      tbl[11] = '{1'b1, 32'h2000,      1'b1, 3, 1'b1, 32'h200c,    32'h2000,      32'h2004};
      tbl[12] = '{1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h2000,    32'h0,         32'h0};
      tbl[13] = '{1'b0, 32'h0,         1'b1, 1, 1'b1, 32'h2004,    32'h2000,      32'h2004};
      tbl[14] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1, 1'b1, 32'h2008,    32'h2004,      32'h2008};
      tbl[15] = '{1'b0, 32'h0,         1'b0, 0, 1'b0, 32'hFFFF_FFFC, 32'h0,       32'h0};
      tbl[16] = '{1'b0, 32'h0,         1'b0, 1, 1'b1, 32'h0,       32'hFFFF_FFFC, 32'h0};
      tbl[17] = '{1'b1, 32'h3000,      1'b1, 2, 1'b1, 32'h4,       32'hFFFF_FFFC, 32'h0};
      tbl[18] = '{1'b0, 32'h0,         1'b1, 0, 1'b0, 32'h3000,    32'h0,         32'h0};
      tbl[19] = '{1'b0, 32'h0,         1'b1, 1, 1'b1, 32'h3004,    32'h3000,      32'h3004};

      reset        = 1'b1;
      i_redirect   = 1'b0;
      i_redirectPC = '0;
      i_deqReady   = 1'b0;
      #3;
      chk_reset();
      @(negedge clk);
      reset = 1'b0;

`ifndef FETCHQ_BYPASS_EN
      // Directed table: outputs expected in the cycle the row's inputs are applied.
      for (int i = 0; i < 20; i++) begin
         i_redirect   = tbl[i].redir;
         i_redirectPC = tbl[i].rpc;
         i_deqReady   = tbl[i].rdy;
         #1;
         chk($sformatf("t%0d_count", i), 32'(o_count), tbl[i].e_cnt);
         chk($sformatf("t%0d_valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
         chk($sformatf("t%0d_pc", i), o_PC, tbl[i].e_pc);
         chk($sformatf("t%0d_ipc", i), o_instPC, tbl[i].e_ipc);
         chk($sformatf("t%0d_ipc4", i), o_instPCPlus4, tbl[i].e_ipc4);
         chk($sformatf("t%0d_inst", i), o_inst,
             tbl[i].e_valid ? imem(tbl[i].e_ipc) : 32'h13);
         @(negedge clk);
      end
`endif

      // Asynchronous reset asserted between edges with a busy queue.
      i_redirect = 1'b0;
      i_deqReady = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_reset();
      @(negedge clk);
      reset = 1'b0;

      // Randomized traffic against a plain queue model.
      q.delete();
      mpc = 32'h1_0000;
      for (int c = 0; c < 3000; c++) begin
         logic        empty_m, byp, valid_m, rdy, redir;
         logic [31:0] rpc, e_inst, e_ipc, e_ipc4;
         redir = ($urandom_range(0, 15) == 0);
         rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         rdy   = ($urandom_range(0, 2) != 0) ^ (c[9] & c[8]);
         i_redirect   = redir;
         i_redirectPC = rpc;
         i_deqReady   = rdy;

         empty_m = (q.size() == 0);
`ifdef FETCHQ_BYPASS_EN
         byp = empty_m & ~redir;
`else
         byp = 1'b0;
`endif
         valid_m = !empty_m || byp;
         if (byp) begin
            e_inst = imem(mpc); e_ipc = mpc; e_ipc4 = mpc + 32'd4;
         end else if (!empty_m) begin
            e_inst = q[0].inst; e_ipc = q[0].pc; e_ipc4 = q[0].pc + 32'd4;
         end else begin
            e_inst = 32'h13; e_ipc = 32'h0; e_ipc4 = 32'h0;
         end
         #1;
         chk("r_pc", o_PC, mpc);
         chk("r_count", 32'(o_count), 32'(q.size()));
         chk("r_valid", 32'(o_valid), 32'(valid_m));
         chk("r_inst", o_inst, e_inst);
         chk("r_ipc", o_instPC, e_ipc);
         chk("r_ipc4", o_instPCPlus4, e_ipc4);

         @(posedge clk);
         if (redir) begin
            q.delete();
            mpc = rpc;
         end else if (byp && rdy) begin
            mpc = mpc + 32'd4;
         end else begin
            if (valid_m && rdy) void'(q.pop_front());
            if (q.size() < 4) begin
               q.push_back('{imem(mpc), mpc});
               mpc = mpc + 32'd4;
            end
         end
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
